// File: rtl/w_update_seq.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : w_update_seq                                                   |
// | Purpose  : Weight bank, tap delay line and sequencer that walks each tap  |
// |            through one shared LMS update-term stage per cycle.            |
// | Revision : 1.0  initial release                                           |
// +---------------------------------------------------------------------------+
module w_update_seq #(
   parameter int               WIDTH     = 16,
   parameter int               QP        = 12,
   parameter int               TAPS      = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [WIDTH-1:0]         x_in,
   input  logic                     x_valid,
   input  logic [WIDTH-1:0]         mu_error,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   output logic                     overrun,
   output logic [WIDTH-1:0]         upd_x_n,
   output logic [WIDTH-1:0]         upd_mu_error,
   output logic [WIDTH-1:0]         upd_weight,
   input  logic [WIDTH-1:0]         upd_new_weight,
   input  logic [$clog2(TAPS)-1:0]  rd_addr,
   output logic [WIDTH-1:0]         rd_weight
);

   localparam int              AW     = $clog2(TAPS);
   localparam logic [AW-1:0]   c_last = AW'(TAPS - 1);
   localparam logic [AW:0]     c_taps = (AW + 1)'(TAPS);

   generate
      if (TAPS < 2 || QP < 0 || QP >= WIDTH) begin : g_param_check
         $error("w_update_seq: unsupported TAPS/QP/WIDTH combination");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_UPDATE = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic             w_accept;
   logic [AW-1:0]    r_idx;
   logic [AW-1:0]    w_sel;
   logic [WIDTH-1:0] r_mu;
   logic             r_overrun;
   logic [WIDTH-1:0] r_w   [TAPS];
   logic [WIDTH-1:0] r_xdl [TAPS];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_accept = 1'b1;
               w_next   = S_UPDATE;
            end
         end
         S_UPDATE: begin
            busy = 1'b1;
            if (r_idx == c_last) begin
               w_next = S_DONE;
            end
         end
         S_DONE: begin
            done   = 1'b1;
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // Shift and start may coincide in IDLE; the pass then reads the shifted line.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_idx     <= '0;
         r_mu      <= '0;
         r_overrun <= 1'b0;
         for (int k = 0; k < TAPS; k++) begin
            r_w[k]   <= RESET_VAL;
            r_xdl[k] <= '0;
         end
      end else begin
         if (x_valid) begin
            if (r_state == S_UPDATE) begin
               r_overrun <= 1'b1;
            end else begin
               r_xdl[0] <= x_in;
               for (int k = 1; k < TAPS; k++) begin
                  r_xdl[k] <= r_xdl[k-1];
               end
            end
         end
         if (w_accept) begin
            r_mu      <= mu_error;
            r_idx     <= '0;
            r_overrun <= 1'b0;
         end
         if (r_state == S_UPDATE) begin
            r_w[r_idx] <= upd_new_weight;
            r_idx      <= (r_idx == c_last) ? '0 : r_idx + 1'b1;
         end
      end
   end

   assign w_sel        = (r_state == S_UPDATE) ? r_idx : '0;
   assign upd_x_n      = r_xdl[w_sel];
   assign upd_weight   = r_w[w_sel];
   assign upd_mu_error = r_mu;
   assign overrun      = r_overrun;

   always_comb begin
      rd_weight = '0;
      if ({1'b0, rd_addr} < c_taps) begin
         rd_weight = r_w[rd_addr];
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_w_update_seq.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : tb_w_update_seq                                                |
// | Purpose  : Directed self-checking bench for w_update_seq (TAPS=4, QP=12). |
// | Revision : 1.0  initial release                                           |
// +---------------------------------------------------------------------------+
module tb_w_update_seq;

   logic        clk = 1'b0;
   int          tests = 0;
   int          fails = 0;

   // main instance, RESET_VAL = 0
   logic        reset, x_valid, start, busy, done, overrun;
   logic [15:0] x_in, mu_error, upd_x_n, upd_mu_error, upd_weight, upd_new_weight, rd_weight;
   logic [1:0]  rd_addr;

   // second instance, RESET_VAL = 16'h7FF0
   logic        b_reset, b_x_valid, b_start, b_busy, b_done, b_overrun;
   logic [15:0] b_x_in, b_mu_error, b_upd_x_n, b_upd_mu_error, b_upd_weight, b_upd_new_weight, b_rd_weight;
   logic [1:0]  b_rd_addr;

   always #5 clk = ~clk;

   // Behavioural update term: w + round-half-up(x*mu_e >> 12), wrapping to 16 bits.
   function automatic logic [15:0] upd_term(input logic [15:0] x, input logic [15:0] mu, input logic [15:0] w);
      logic signed [31:0] p;
      p = $signed(x) * $signed(mu);
      p = p + 32'sd2048;
      return w + p[27:12];
   endfunction

   assign upd_new_weight   = upd_term(upd_x_n, upd_mu_error, upd_weight);
   assign b_upd_new_weight = upd_term(b_upd_x_n, b_upd_mu_error, b_upd_weight);

   w_update_seq #(.WIDTH(16), .QP(12), .TAPS(4), .RESET_VAL(16'h0000)) dut (
      .clk(clk), .reset(reset), .x_in(x_in), .x_valid(x_valid), .mu_error(mu_error),
      .start(start), .busy(busy), .done(done), .overrun(overrun),
      .upd_x_n(upd_x_n), .upd_mu_error(upd_mu_error), .upd_weight(upd_weight),
      .upd_new_weight(upd_new_weight), .rd_addr(rd_addr), .rd_weight(rd_weight)
   );

   w_update_seq #(.WIDTH(16), .QP(12), .TAPS(4), .RESET_VAL(16'h7FF0)) dut_b (
      .clk(clk), .reset(b_reset), .x_in(b_x_in), .x_valid(b_x_valid), .mu_error(b_mu_error),
      .start(b_start), .busy(b_busy), .done(b_done), .overrun(b_overrun),
      .upd_x_n(b_upd_x_n), .upd_mu_error(b_upd_mu_error), .upd_weight(b_upd_weight),
      .upd_new_weight(b_upd_new_weight), .rd_addr(b_rd_addr), .rd_weight(b_rd_weight)
   );

   // Stimulus helpers (no checking). All driving happens just after a falling edge.
   task automatic shift(input logic [15:0] x);
      x_in    = x;
      x_valid = 1'b1;
      @(negedge clk);
      x_valid = 1'b0;
   endtask

   task automatic read_w(input int a, output logic [15:0] v);
      rd_addr = 2'(a);
      #1;
      v = rd_weight;
   endtask

   // Issues start, then counts busy cycles and the cycle index (1 = first after the start edge) of done.
   task automatic do_pass(input logic [15:0] mu, output int busy_n, output int done_at,
                          output logic [15:0] fx, output logic [15:0] fw, output logic [15:0] fmu);
      busy_n   = 0;
      done_at  = -1;
      mu_error = mu;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      fx       = upd_x_n;
      fw       = upd_weight;
      fmu      = upd_mu_error;
      for (int k = 1; k <= 20; k++) begin
         if (busy) busy_n++;
         if (done) begin
            done_at = k;
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
   endtask

   task automatic test_reset;
      logic [15:0] v;
      for (int a = 0; a < 4; a++) begin
         read_w(a, v);
         tests++;
         if (v !== 16'h0000) begin
            fails++;
            $display("FAIL reset_w%0d: got %h expected 0000", a, v);
         end
      end
      tests++;
      if ({busy, done, overrun} !== 3'b000) begin
         fails++;
         $display("FAIL reset_flags: got busy/done/overrun=%b expected 000", {busy, done, overrun});
      end
   endtask

   task automatic test_update_pass;
      logic [15:0] v, fx, fw, fmu;
      logic [15:0] exp_w [4] = '{16'd51, 16'd103, 16'd205, 16'd410};
      int busy_n, done_at;
      shift(16'd4096);
      shift(16'd2048);
      shift(16'd1024);
      shift(16'd512);
      do_pass(16'd410, busy_n, done_at, fx, fw, fmu);
      tests++;
      if (busy_n !== 4) begin
         fails++;
         $display("FAIL pass_busy_cycles: got %0d expected 4", busy_n);
      end
      tests++;
      if (done_at !== 5) begin
         fails++;
         $display("FAIL pass_done_latency: got %0d expected 5", done_at);
      end
      tests++;
      if ({fx, fw, fmu} !== {16'd512, 16'd0, 16'd410}) begin
         fails++;
         $display("FAIL pass_first_upd: got x=%0d w=%0d mu=%0d expected x=512 w=0 mu=410", fx, fw, fmu);
      end
      for (int a = 0; a < 4; a++) begin
         read_w(a, v);
         tests++;
         if (v !== exp_w[a]) begin
            fails++;
            $display("FAIL pass_w%0d: got %0d expected %0d", a, $signed(v), $signed(exp_w[a]));
         end
      end
   endtask

   task automatic test_negative_mu;
      logic [15:0] v, fx, fw, fmu;
      logic [15:0] exp_w [4] = '{16'd0, 16'd1, 16'd0, 16'd0};
      int busy_n, done_at;
      do_pass(-16'sd410, busy_n, done_at, fx, fw, fmu);
      tests++;
      if (done_at !== 5) begin
         fails++;
         $display("FAIL neg_done_latency: got %0d expected 5", done_at);
      end
      for (int a = 0; a < 4; a++) begin
         read_w(a, v);
         tests++;
         if (v !== exp_w[a]) begin
            fails++;
            $display("FAIL neg_w%0d: got %0d expected %0d", a, $signed(v), $signed(exp_w[a]));
         end
      end
   endtask

   task automatic test_overrun;
      logic [15:0] v;
      logic [15:0] exp_w [4] = '{16'd51, 16'd104, 16'd205, 16'd410};
      int seen_done, extra_busy;
      mu_error = 16'd410;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      x_in     = 16'd999;
      x_valid  = 1'b1;
      start    = 1'b1;
      @(negedge clk);
      x_valid  = 1'b0;
      start    = 1'b0;
      tests++;
      if (overrun !== 1'b1) begin
         fails++;
         $display("FAIL ovr_set: got %b expected 1", overrun);
      end
      seen_done = 0;
      for (int k = 0; k < 20 && seen_done == 0; k++) begin
         if (done) seen_done = 1;
         @(negedge clk);
      end
      tests++;
      if (seen_done !== 1) begin
         fails++;
         $display("FAIL ovr_done_timeout: got no done expected done within 20 cycles");
      end
      extra_busy = 0;
      for (int k = 0; k < 6; k++) begin
         if (busy) extra_busy++;
         @(negedge clk);
      end
      tests++;
      if (extra_busy !== 0) begin
         fails++;
         $display("FAIL ovr_no_second_pass: got %0d busy cycles expected 0", extra_busy);
      end
      for (int a = 0; a < 4; a++) begin
         read_w(a, v);
         tests++;
         if (v !== exp_w[a]) begin
            fails++;
            $display("FAIL ovr_w%0d: got %0d expected %0d", a, $signed(v), $signed(exp_w[a]));
         end
      end
      tests++;
      if (overrun !== 1'b1) begin
         fails++;
         $display("FAIL ovr_sticky: got %b expected 1", overrun);
      end
      mu_error = 16'd0;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      tests++;
      if (overrun !== 1'b0) begin
         fails++;
         $display("FAIL ovr_clear: got %b expected 0", overrun);
      end
      repeat (6) @(negedge clk);
   endtask

   task automatic test_reset_mid_pass;
      logic [15:0] v;
      int seen_done;
      mu_error = 16'd410;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      @(negedge clk);
      reset    = 1'b0;
      #1;
      tests++;
      if (busy !== 1'b0) begin
         fails++;
         $display("FAIL rmid_busy: got %b expected 0", busy);
      end
      for (int a = 0; a < 4; a++) begin
         read_w(a, v);
         tests++;
         if (v !== 16'h0000) begin
            fails++;
            $display("FAIL rmid_w%0d: got %0d expected 0", a, $signed(v));
         end
      end
      seen_done = 0;
      @(negedge clk);
      for (int k = 0; k < 8; k++) begin
         if (k == 2) reset = 1'b1;
         if (done || busy) seen_done = 1;
         @(negedge clk);
      end
      tests++;
      if (seen_done !== 0) begin
         fails++;
         $display("FAIL rmid_no_done: got done/busy activity expected none");
      end
   endtask

   task automatic test_wrap;
      logic [15:0] v;
      logic [15:0] exp_w [4] = '{16'h8FF0, 16'h7FF0, 16'h7FF0, 16'h7FF0};
      int seen_done;
      b_x_in    = 16'd4096;
      b_x_valid = 1'b1;
      @(negedge clk);
      b_x_valid  = 1'b0;
      b_mu_error = 16'd4096;
      b_start    = 1'b1;
      @(negedge clk);
      b_start    = 1'b0;
      seen_done  = 0;
      for (int k = 0; k < 20 && seen_done == 0; k++) begin
         if (b_done) seen_done = 1;
         @(negedge clk);
      end
      tests++;
      if (seen_done !== 1) begin
         fails++;
         $display("FAIL wrap_done_timeout: got no done expected done within 20 cycles");
      end
      for (int a = 0; a < 4; a++) begin
         b_rd_addr = 2'(a);
         #1;
         v = b_rd_weight;
         tests++;
         if (v !== exp_w[a]) begin
            fails++;
            $display("FAIL wrap_w%0d: got %h expected %h", a, v, exp_w[a]);
         end
      end
   endtask

   initial begin
      reset      = 1'b0;
      x_in       = '0;
      x_valid    = 1'b0;
      mu_error   = '0;
      start      = 1'b0;
      rd_addr    = '0;
      b_reset    = 1'b0;
      b_x_in     = '0;
      b_x_valid  = 1'b0;
      b_mu_error = '0;
      b_start    = 1'b0;
      b_rd_addr  = '0;
      repeat (2) @(negedge clk);
      test_reset();
      reset   = 1'b1;
      b_reset = 1'b1;
      @(negedge clk);
      test_update_pass();
      test_negative_mu();
      test_overrun();
      test_reset_mid_pass();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
